hc161_timer_ctrl: RTL and testbench

- Sequencer for a single HC161 4-bit synchronous counter instance.
- Turns it into a programmable interval timer: preloads the counter through PE/D, gates counting with CEP/CET, and watches TC.
- Supports one-shot and periodic/repeat operation, with a start/stop handshake and a per-interval done pulse.
- Sits beside the counter at the same hierarchy level; shares Clk and MR with it.

---
 rtl/hc161_timer_ctrl.sv | 103 ++++++++++
 tb/tb_hc161_timer_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc161_timer_ctrl.sv
// hc161_timer_ctrl: interval-timer sequencer for one HC161 counter.
// Preloads the counter, gates counting, and checks the loaded value.
module hc161_timer_ctrl #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       MR,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] period,
    input  logic [3:0] reps,
    input  logic [3:0] cnt_q,
    input  logic       cnt_tc,
    output logic       cnt_pe,
    output logic       cnt_cep,
    output logic       cnt_cet,
    output logic [3:0] cnt_d,
    output logic       busy,
    output logic       done,
    output logic [3:0] ticks_left,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;

    logic [1:0] state;
    logic [3:0] period_q;
    logic [3:0] reps_q;
    logic       chk_pend;

    logic [3:0] load_val;
    logic       in_count;
    logic       mismatch;
    logic       last_tick;
    logic       tc_hit;
    logic       reload;

    // Derived control terms shared by outputs and next-state logic
    always_comb begin
        load_val  = 4'd0 - period_q;
        in_count  = (state == S_COUNT);
        mismatch  = CHECK_EN && in_count && chk_pend
                    && (cnt_q != load_val);
        last_tick = (reps_q != 4'd0) && (ticks_left == 4'd1);
        tc_hit    = in_count && cnt_tc && !mismatch;
        reload    = tc_hit && !stop && !last_tick;
    end

    // Counter control; CEP drops on the final TC so Q parks at 15
    always_comb begin
        busy    = (state != S_IDLE);
        cnt_d   = (state == S_IDLE) ? 4'd0 : load_val;
        cnt_cet = in_count;
        cnt_cep = in_count && !(tc_hit && !reload);
        cnt_pe  = !((state == S_LOAD) || reload);
    end

    // Sequencer state, captured settings, done pulse and error flag
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            state      <= S_IDLE;
            period_q   <= 4'd0;
            reps_q     <= 4'd0;
            ticks_left <= 4'd0;
            chk_pend   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= tc_hit;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        period_q   <= period;
                        reps_q     <= reps;
                        ticks_left <= reps;
                        err        <= 1'b0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    chk_pend <= 1'b1;
                    state    <= stop ? S_IDLE : S_COUNT;
                end
                S_COUNT: begin
                    chk_pend <= reload;
                    if (mismatch) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        if (tc_hit && (reps_q != 4'd0))
                            ticks_left <= ticks_left - 4'd1;
                        if (stop || (tc_hit && last_tick))
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc161_timer_ctrl.sv
// tb_hc161_timer_ctrl: bench for the HC161 interval-timer sequencer.
// Drives an HC161 model and checks against arithmetic expectations.
module tb_hc161_timer_ctrl;

    logic       Clk = 1'b0;
    logic       MR;
    logic       start;
    logic       stop;
    logic [3:0] period;
    logic [3:0] reps;
    logic [3:0] cnt_q;
    logic       cnt_tc;
    logic       cnt_pe;
    logic       cnt_cep;
    logic       cnt_cet;
    logic [3:0] cnt_d;
    logic       busy;
    logic       done;
    logic [3:0] ticks_left;
    logic       err;

    logic [3:0] q;
    logic       bad;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    // HC161 counter model
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR)
            q <= 4'd0;
        else if (!cnt_pe)
            q <= cnt_d;
        else if (cnt_cep && cnt_cet)
            q <= q + 4'd1;
    end

    assign cnt_tc = cnt_cet && (q == 4'd15);
    assign cnt_q  = bad ? 4'd0 : q;

    hc161_timer_ctrl #(.CHECK_EN(1'b1)) dut (
        .Clk       (Clk),
        .MR        (MR),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .reps      (reps),
        .cnt_q     (cnt_q),
        .cnt_tc    (cnt_tc),
        .cnt_pe    (cnt_pe),
        .cnt_cep   (cnt_cep),
        .cnt_cet   (cnt_cet),
        .cnt_d     (cnt_d),
        .busy      (busy),
        .done      (done),
        .ticks_left(ticks_left),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit is_tc(input int r, input int n,
                                 input int rp, input int end_r);
        if (r < n + 1 || r > end_r) return 1'b0;
        if ((r - n - 1) % n != 0) return 1'b0;
        if (rp != 0 && (r - n - 1) / n >= rp) return 1'b0;
        return 1'b1;
    endfunction

    // One run: start in relative cycle 0, optional stop at stop_at
    task automatic run_case(input int n_raw, input int rp,
                            input int stop_at);
        int n, lv, nat_end, end_r, q_after, ntc, passed, exp_t;
        bit end_tc, tc_r, act, cep_e;
        n = (n_raw == 0) ? 16 : n_raw;
        lv = (16 - n) % 16;
        nat_end = (rp == 0) ? 32'h3fff_ffff : n + 1 + (rp - 1) * n;
        end_r = (stop_at > 0 && stop_at < nat_end) ? stop_at : nat_end;
        end_tc = is_tc(end_r, n, rp, end_r);
        q_after = end_tc ? 15 : (lv + (end_r - 2) % n + 1) % 16;
        ntc = (end_r >= n + 1) ? (end_r - n - 1) / n + 1 : 0;
        for (int r = 0; r <= end_r + 2; r++) begin
            if (r == 0) begin
                start  = 1'b1;
                period = 4'(n_raw);
                reps   = 4'(rp);
            end else begin
                start  = (r <= end_r) ? 1'($urandom_range(0, 1)) : 1'b0;
                period = 4'($urandom);
                reps   = 4'($urandom);
            end
            stop = (stop_at > 0 && r == stop_at);
            @(negedge Clk);
            if (r >= 1) begin
                act   = (r <= end_r);
                tc_r  = is_tc(r, n, rp, end_r);
                cep_e = act && r >= 2 && !(r == end_r && end_tc);
                passed = (r <= n + 1) ? 0 : (r - n - 2) / n + 1;
                if (passed > ntc) passed = ntc;
                exp_t = (rp == 0) ? 0 : rp - passed;
                chk("busy", busy, act);
                chk("err", err, 0);
                chk("done", done, is_tc(r - 1, n, rp, end_r));
                chk("ticks_left", ticks_left, exp_t);
                chk("cnt_d", cnt_d, act ? lv : 0);
                chk("cnt_cet", cnt_cet, act && r >= 2);
                chk("cnt_cep", cnt_cep, cep_e);
                chk("cnt_pe", cnt_pe,
                    !(r == 1 || (tc_r && r != end_r)));
                chk("cnt_tc", cnt_tc, tc_r);
                if (r >= 2)
                    chk("cnt_q", cnt_q,
                        act ? (lv + (r - 2) % n) % 16 : q_after);
            end
            next_cycle();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Corrupt the counter readback on the first COUNT cycle
    task automatic fault_case();
        period = 4'd5;
        reps   = 4'd1;
        start  = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge Clk);
        chk("fault_pe_load", cnt_pe, 0);
        next_cycle();
        bad = 1'b1;
        @(negedge Clk);
        chk("fault_busy_c2", busy, 1);
        next_cycle();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk("fault_err", err, 1);
            chk("fault_busy", busy, 0);
            chk("fault_done", done, 0);
            chk("fault_cep", cnt_cep, 0);
            next_cycle();
        end
    endtask

    initial begin
        int n_raw, rp, st, n;
        MR     = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = 4'd0;
        reps   = 4'd0;
        bad    = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge Clk);
        chk("rst_pe", cnt_pe, 1);
        chk("rst_cep", cnt_cep, 0);
        chk("rst_cet", cnt_cet, 0);
        chk("rst_d", cnt_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ticks", ticks_left, 0);
        chk("rst_err", err, 0);
        next_cycle();
        MR = 1'b1;
        stop = 1'b1;
        next_cycle();
        @(negedge Clk);
        chk("idle_stop_busy", busy, 0);
        next_cycle();
        stop = 1'b0;

        run_case(5, 1, 0);
        run_case(3, 4, 0);
        run_case(0, 1, 0);
        run_case(1, 0, 10);
        run_case(8, 0, 17);

        for (int k = 0; k < 10; k++) begin
            n_raw = $urandom_range(0, 15);
            rp = $urandom_range(0, 4);
            n = (n_raw == 0) ? 16 : n_raw;
            if (rp == 0)
                st = ($urandom_range(0, 1) == 1)
                     ? n + 1 + n * $urandom_range(0, 2)
                     : $urandom_range(2, 3 * n);
            else if ($urandom_range(0, 1) == 1)
                st = 0;
            else
                st = $urandom_range(2, n + 1 + (rp - 1) * n);
            run_case(n_raw, rp, st);
        end

        fault_case();
        run_case(5, 1, 0);

        // Async reset in the middle of a free-running count
        period = 4'd4;
        reps   = 4'd0;
        start  = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 1; i < 6; i++) next_cycle();
        start = 1'b1;
        #2;
        chk("pre_rst_done", done, 1);
        chk("pre_rst_busy", busy, 1);
        MR = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_cep", cnt_cep, 0);
        chk("arst_q", cnt_q, 0);
        start = 1'b0;
        next_cycle();
        MR = 1'b1;
        @(negedge Clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ticks", ticks_left, 0);
        next_cycle();

        // Reset also clears a sticky error
        fault_case();
        #1;
        MR = 1'b0;
        #1;
        chk("arst_err_clear", err, 0);
        next_cycle();
        MR = 1'b1;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
